// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - size codes, FSM encoding and timeout width for data_mem_access
package data_mem_pkg;

    // Size codes shared by the load and store request fields
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Width of the m_ack wait counter; TIMEOUT_CYC must fit in it
    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Half on an odd byte, or word not on a 4-byte boundary
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// rtl/data_mem_lane.sv - byte/half lane extract with sign extension and store merge
//
// Ports:
//   size_i    size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//   addr_lo_i byte offset within the word (little-endian lanes)
//   rword_i   word read from memory
//   wdata_i   store data, byte/half taken from the low bits
//   ld_data_o sign-extended load result
//   st_word_o rword_i with the addressed byte/half replaced (whole wdata_i for a word)
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_v = rword_i[7:0];
            2'd1:    byte_v = rword_i[15:8];
            2'd2:    byte_v = rword_i[23:16];
            default: byte_v = rword_i[31:24];
        endcase
        // addr bit 0 is ignored for halves; the trap, when built in, catches it upstream
        half_v = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        ld_data_o = rword_i;
        st_word_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{24{byte_v[7]}}, byte_v};
                st_word_o = rword_i;
                case (addr_lo_i)
                    2'd0:    st_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    st_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    st_word_o[23:16] = wdata_i[7:0];
                    default: st_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data_o = {{16{half_v[15]}}, half_v};
                st_word_o = rword_i;
                if (addr_lo_i[1]) st_word_o[31:16] = wdata_i[15:0];
                else              st_word_o[15:0]  = wdata_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// rtl/data_mem_access.sv - load/store unit driving a word-wide handshaked data memory
//
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word -> err, no memory access).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid, mem_read,
//   mem_write, addr, wdata     request side, sampled only while idle
//   busy, done, rdata, err     status and sign-extended load result
//   m_req, m_we, m_addr,
//   m_wdata, m_rdata, m_ack    word-wide memory handshake
module data_mem_access
    import data_mem_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [1:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [MEM_AW-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ack
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic               is_load_q, is_load_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        word_q, word_d;
    logic [MEM_AW-1:0]  m_addr_q, m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               err_pend_q, err_pend_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        ld_data, st_word;
    logic [TMO_W-1:0]   cnt_inc;
    logic               unused_addr;

    assign unused_addr = ^addr[31:MEM_AW+2];

    data_mem_lane u_lane (
        .size_i    (size_q),
        .addr_lo_i (addr_lo_q),
        .rword_i   (word_q),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        size_d     = size_q;
        addr_lo_d  = addr_lo_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_load_d  = (mem_read != SZ_NONE);
                    size_d     = (mem_read != SZ_NONE) ? mem_read : mem_write;
                    addr_lo_d  = addr[1:0];
                    wdata_d    = wdata;
                    m_addr_d   = addr[MEM_AW+1:2];
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                    if ((mem_read == SZ_NONE) == (mem_write == SZ_NONE)) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end else if (TRAP_EN && misaligned(size_d, addr[1:0])) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end else if (mem_write == SZ_WORD) begin
                        m_wdata_d = wdata;
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // ack beats a timeout reached in the same cycle
                if (m_ack) begin
                    word_d  = m_rdata;
                    state_d = is_load_q ? DONE : MERGE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_LIM) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            MERGE: begin
                m_wdata_d = st_word;
                cnt_d     = '0;
                state_d   = WR;
            end
            WR: begin
                if (m_ack) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_LIM) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                if (is_load_q && !err_pend_q) rdata_d = ld_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            size_q     <= SZ_NONE;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            word_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            size_q     <= size_d;
            addr_lo_q  <= addr_lo_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign m_req   = (state_q == RD) || (state_q == WR);
    assign m_we    = (state_q == WR);
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule
